// File: rtl/apb_requester.sv
// apb_requester
// Converts a simple valid/ready request/response handshake into APB4
// requester transfers. One transfer is outstanding at a time: a request is
// taken in IDLE, driven through SETUP and ACCESS, and its result is held in
// RESP until the upstream side consumes it.
//
// Parameters
//   TIMEOUT_CYCLES  maximum ACCESS cycles before the transfer is aborted
//                   with an error; 0 disables the timeout
//   PPROT_VAL       constant driven on out_pprot
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_write, req_addr,
//   req_wdata, req_wstrb          request payload (1/32/32/4)
//   resp_valid / resp_ready       response handshake
//   resp_rdata, resp_err          response payload (32/1)
//   out_paddr, out_pwrite,
//   out_pwdata, out_pstrb,
//   out_psel, out_penable,
//   out_pprot                     APB4 requester outputs
//   out_pready, out_prdata,
//   out_pslverr                   APB4 completer responses
module apb_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] out_paddr,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] access_count;
  logic        timeout_hit;

  assign out_pprot = PPROT_VAL;

  // The timeout fires in the ACCESS cycle whose count (including itself)
  // reaches TIMEOUT_CYCLES while the completer is still stalling. A pready
  // in that same cycle takes priority, so the check is qualified on !pready.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 32'd0) && !out_pready &&
                  ((access_count + 32'd1) >= TIMEOUT_CYCLES);
  end

  // State register. Reset from any state abandons the transfer outright;
  // nothing is reported upstream for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/select decode. psel/penable and the two valid
  // and ready flags are pure functions of the registered state.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        out_psel   = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The APB address/data/strobe registers are loaded only when a
  // request is accepted, so they stay stable through SETUP and ACCESS and
  // keep their last values afterwards. Read strobes are forced to zero as
  // APB4 requires. The response registers are written only when ACCESS
  // ends, which keeps them stable for the whole of RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_pwrite   <= 1'b0;
      out_paddr    <= '0;
      out_pwdata   <= '0;
      out_pstrb    <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      access_count <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        out_pwrite <= req_write;
        out_paddr  <= req_addr;
        out_pwdata <= req_wdata;
        out_pstrb  <= req_write ? req_wstrb : 4'b0000;
      end

      if (state == SETUP) begin
        access_count <= '0;
      end else if (state == ACCESS && !out_pready) begin
        access_count <= access_count + 32'd1;
      end

      if (state == ACCESS) begin
        if (out_pready) begin
          resp_rdata <= out_pwrite ? 32'd0 : out_prdata;
          resp_err   <= out_pslverr;
        end else if (timeout_hit) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester
// Directed bench for apb_requester built with TIMEOUT_CYCLES=4 so both the
// timeout abort and the "pready on the last allowed cycle" boundary can be
// reached quickly. Inputs change and outputs are sampled on the falling
// edge, away from the active rising edge.
module tb_apb_requester;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pready;
  logic        out_pslverr;
  logic [31:0] out_prdata;

  int checks;
  int failures;

  vec_t vectors[6];

  apb_requester #(
    .TIMEOUT_CYCLES(4),
    .PPROT_VAL     (3'b010)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .out_paddr  (out_paddr),
    .out_pwrite (out_pwrite),
    .out_pwdata (out_pwdata),
    .out_pstrb  (out_pstrb),
    .out_psel   (out_psel),
    .out_penable(out_penable),
    .out_pprot  (out_pprot),
    .out_pready (out_pready),
    .out_pslverr(out_pslverr),
    .out_prdata (out_prdata)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One full cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Compares one sampled value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Presents a request in IDLE and steps to the SETUP cycle. The request
  // inputs are scrambled afterwards so the latched copy is what gets checked.
  task automatic startRequest(input logic write, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    tick();
    req_valid = 1'b0;
    req_write = ~write;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_wstrb = ~wstrb;
  endtask

  // Runs one table vector end to end, checking every cycle of the transfer.
  task automatic applyStimulus(input vec_t v, input string tag);
    checkOutput({tag, "_idle_req_ready"}, {31'd0, req_ready}, 32'd1);
    startRequest(v.write, v.addr, v.wdata, v.wstrb);
    checkOutput({tag, "_setup_psel"}, {31'd0, out_psel}, 32'd1);
    checkOutput({tag, "_setup_penable"}, {31'd0, out_penable}, 32'd0);
    checkOutput({tag, "_setup_req_ready"}, {31'd0, req_ready}, 32'd0);
    checkOutput({tag, "_setup_paddr"}, out_paddr, v.addr);
    checkOutput({tag, "_setup_pwrite"}, {31'd0, out_pwrite}, {31'd0, v.write});
    checkOutput({tag, "_setup_pstrb"}, {28'd0, out_pstrb}, {28'd0, v.exp_pstrb});
    // Completer noise during SETUP must be ignored.
    out_pready  = 1'b1;
    out_pslverr = 1'b1;
    out_prdata  = 32'hBAAD_0000;
    for (int i = 0; i <= v.waits; i++) begin
      tick();
      checkOutput({tag, "_access_psel"}, {31'd0, out_psel}, 32'd1);
      checkOutput({tag, "_access_penable"}, {31'd0, out_penable}, 32'd1);
      checkOutput({tag, "_access_paddr"}, out_paddr, v.addr);
      checkOutput({tag, "_access_pstrb"}, {28'd0, out_pstrb}, {28'd0, v.exp_pstrb});
      if (v.write) begin
        checkOutput({tag, "_access_pwdata"}, out_pwdata, v.wdata);
      end
      checkOutput({tag, "_access_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      out_pready  = (i == v.waits);
      out_pslverr = (i == v.waits) ? v.pslverr : 1'b1;
      out_prdata  = (i == v.waits) ? v.prdata : (32'hDEAD_0000 + i);
    end
    tick();
    out_pready  = 1'b0;
    out_pslverr = 1'b1;
    out_prdata  = 32'hFFFF_FFFF;
    checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({tag, "_resp_psel"}, {31'd0, out_psel}, 32'd0);
    checkOutput({tag, "_resp_penable"}, {31'd0, out_penable}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, v.exp_rdata);
    checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    checkOutput({tag, "_resp_req_ready"}, {31'd0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    out_pslverr = 1'b0;
    checkOutput({tag, "_done_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_done_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    resp_ready  = 1'b0;
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    out_prdata  = '0;

    //               write addr          wdata          wstrb    waits prdata         slverr exp_rdata      err  pstrb
    vectors[0] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'b0000, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4'b0000};
    vectors[1] = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b0101, 3, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0, 4'b0101};
    vectors[2] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000, 1, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 1'b1, 4'b0000};
    vectors[3] = '{1'b1, 32'h0000_0044, 32'h0102_0304, 4'b1111, 0, 32'h2222_2222, 1'b1, 32'h0000_0000, 1'b1, 4'b1111};
    vectors[4] = '{1'b0, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'b1111, 2, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'b0000};
    vectors[5] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 4'b0000, 3, 32'h7777_0004, 1'b0, 32'h7777_0004, 1'b0, 4'b0000};

    // Reset state.
    tick();
    tick();
    checkOutput("rst_psel", {31'd0, out_psel}, 32'd0);
    checkOutput("rst_penable", {31'd0, out_penable}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_paddr", out_paddr, 32'd0);
    checkOutput("rst_pwdata", out_pwdata, 32'd0);
    checkOutput("rst_pstrb", {28'd0, out_pstrb}, 32'd0);
    checkOutput("rst_pwrite", {31'd0, out_pwrite}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_pprot", {29'd0, out_pprot}, 32'd2);
    reset = 1'b0;
    checkOutput("rst_release_req_ready", {31'd0, req_ready}, 32'd1);

    // resp_ready outside RESP does nothing.
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("idle_resp_ready_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("idle_resp_ready_resp_valid", {31'd0, resp_valid}, 32'd0);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
    end

    // Timeout: pready held low for all four allowed ACCESS cycles.
    startRequest(1'b0, 32'h1000_0000, 32'h0, 4'h0);
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    out_prdata  = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("to_access%0d_psel", i), {31'd0, out_psel}, 32'd1);
      checkOutput($sformatf("to_access%0d_resp_valid", i), {31'd0, resp_valid}, 32'd0);
    end
    tick();
    checkOutput("to_psel_dropped", {31'd0, out_psel}, 32'd0);
    checkOutput("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("to_resp_err", {31'd0, resp_err}, 32'd1);
    checkOutput("to_resp_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("to_done_req_ready", {31'd0, req_ready}, 32'd1);

    // Backpressure: response held for five cycles while a second request waits.
    startRequest(1'b0, 32'h2000_0004, 32'h0, 4'h0);
    out_pready = 1'b1;
    out_prdata = 32'h1357_9BDF;
    tick();
    tick();
    out_pready = 1'b0;
    out_prdata = 32'hEEEE_EEEE;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h3000_0008;
    req_wdata  = 32'h0F0F_0F0F;
    req_wstrb  = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
      checkOutput($sformatf("bp%0d_resp_rdata", i), resp_rdata, 32'h1357_9BDF);
      checkOutput($sformatf("bp%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
      checkOutput($sformatf("bp%0d_paddr", i), out_paddr, 32'h2000_0004);
      tick();
    end
    resp_ready = 1'b1;
    checkOutput("bp_handshake_resp_valid", {31'd0, resp_valid}, 32'd1);
    tick();
    resp_ready = 1'b0;
    checkOutput("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("bp_idle_psel", {31'd0, out_psel}, 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("bp_second_setup_psel", {31'd0, out_psel}, 32'd1);
    checkOutput("bp_second_paddr", out_paddr, 32'h3000_0008);
    checkOutput("bp_second_pwrite", {31'd0, out_pwrite}, 32'd1);
    checkOutput("bp_second_pstrb", {28'd0, out_pstrb}, 32'h8);
    checkOutput("bp_second_pwdata", out_pwdata, 32'h0F0F_0F0F);
    out_pready = 1'b1;
    tick();
    tick();
    out_pready = 1'b0;
    checkOutput("bp_second_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("bp_second_resp_rdata", resp_rdata, 32'd0);
    checkOutput("bp_second_resp_err", {31'd0, resp_err}, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset in the middle of ACCESS abandons the transfer.
    startRequest(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    out_pready = 1'b0;
    tick();
    checkOutput("mid_rst_access_psel", {31'd0, out_psel}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_psel", {31'd0, out_psel}, 32'd0);
    checkOutput("mid_rst_penable", {31'd0, out_penable}, 32'd0);
    checkOutput("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("mid_rst_paddr", out_paddr, 32'd0);
    reset = 1'b0;
    checkOutput("mid_rst_release_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    checkOutput("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("mid_rst_idle_psel", {31'd0, out_psel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
